alu_issue_pipe: RTL and testbench

//  Parametrised ID/EX/MEM/WB integer back-end: accepts decoded ops on a valid/ready port, reads an

---
 rtl/alu_issue_pipe_pkg.sv | 15 +
 rtl/alu_issue_pipe_if.sv | 26 ++
 rtl/alu_issue_pipe_regfile.sv | 35 +++
 rtl/alu_issue_pipe.sv | 113 +++++++++++
 tb/tb_alu_issue_pipe.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pipe_pkg.sv
// pipe_pkg: opcodes, default datapath width and EX-stage control record for alu_issue_pipe
package pipe_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;
    typedef struct packed {
        logic       valid;
        logic [2:0] op;
        logic       regwrite;
    } ctrl_t;
endpackage

// File: rtl/alu_issue_pipe_if.sv
// alu_issue_pipe_if: issue bus, retire bus and debug read port of alu_issue_pipe
//   master = decoder/debugger side, slave = pipe side
//   start_i/issue_valid_i/issue_ready_o + op/rs/rt/rd/imm/use_imm/regwrite : issue handshake
//   wb_valid_o/wb_addr_o/wb_data_o : retiring register write
//   dbg_addr_i/dbg_data_o : combinational register read
interface alu_issue_pipe_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            start_i, issue_valid_i, issue_ready_o;
    logic [2:0]      op_i;
    logic [AW-1:0]   rs_i, rt_i, rd_i, dbg_addr_i;
    logic [XLEN-1:0] imm_i;
    logic            use_imm_i, regwrite_i;
    logic            wb_valid_o;
    logic [AW-1:0]   wb_addr_o;
    logic [XLEN-1:0] wb_data_o, dbg_data_o;
    modport master (
        output start_i, issue_valid_i, op_i, rs_i, rt_i, rd_i, imm_i, use_imm_i, regwrite_i, dbg_addr_i,
        input  issue_ready_o, wb_valid_o, wb_addr_o, wb_data_o, dbg_data_o
    );
    modport slave (
        input  start_i, issue_valid_i, op_i, rs_i, rt_i, rd_i, imm_i, use_imm_i, regwrite_i, dbg_addr_i,
        output issue_ready_o, wb_valid_o, wb_addr_o, wb_data_o, dbg_data_o
    );
endinterface

// File: rtl/alu_issue_pipe_regfile.sv
// pipe_regfile: NREGS x XLEN register file, R0 reads zero, write-through on all read ports
//   clk_i, rst_i (async active-low clear); we_i/wa_i/wd_i write port;
//   ra_i->a_o, rb_i->b_o operand reads; rdbg_i->dbg_o debug read
module pipe_regfile #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [AW-1:0]   ra_i,
    input  logic [AW-1:0]   rb_i,
    input  logic [AW-1:0]   rdbg_i,
    output logic [XLEN-1:0] a_o,
    output logic [XLEN-1:0] b_o,
    output logic [XLEN-1:0] dbg_o
);
    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we_i && wa_i != '0) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // a write landing this cycle is visible to a read of the same address
    assign a_o   = (ra_i   == '0) ? '0 : (we_i && wa_i == ra_i)   ? wd_i : mem_q[ra_i];
    assign b_o   = (rb_i   == '0) ? '0 : (we_i && wa_i == rb_i)   ? wd_i : mem_q[rb_i];
    assign dbg_o = (rdbg_i == '0) ? '0 : (we_i && wa_i == rdbg_i) ? wd_i : mem_q[rdbg_i];
endmodule

// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: ID/EX/MEM/WB integer back-end with forwarding, multi-cycle MUL and issue back-pressure
//   clk_i, rst_i (async active-low); bus = alu_issue_pipe_if.slave (issue, retire, debug ports)
module alu_issue_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NREGS   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_issue_pipe_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(MUL_LAT + 1);

    ctrl_t           ex_q;
    logic [AW-1:0]   ex_rs_q, ex_rt_q, ex_rd_q;
    logic            ex_imm_q;
    logic [XLEN-1:0] ex_a_q, ex_b_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_valid_q, mem_rw_q;
    logic [AW-1:0]   mem_rd_q;
    logic [XLEN-1:0] mem_data_q;
    logic            wb_valid_q;
    logic [AW-1:0]   wb_addr_q;
    logic [XLEN-1:0] wb_data_q;
    logic [XLEN-1:0] rf_a, rf_b, fwd_a, fwd_b, alu_d;
    logic            mem_fwd, ex_stall, ready, fire;

    pipe_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (wb_valid_q),
        .wa_i   (wb_addr_q),
        .wd_i   (wb_data_q),
        .ra_i   (bus.rs_i),
        .rb_i   (bus.rt_i),
        .rdbg_i (bus.dbg_addr_i),
        .a_o    (rf_a),
        .b_o    (rf_b),
        .dbg_o  (bus.dbg_data_o)
    );

    // MEM (younger) beats WB; wb_valid_q already excludes R0 and non-writing ops
    always_comb begin
        mem_fwd  = mem_valid_q && mem_rw_q && mem_rd_q != '0;
        fwd_a    = (mem_fwd && mem_rd_q == ex_rs_q) ? mem_data_q :
                   (wb_valid_q && wb_addr_q == ex_rs_q) ? wb_data_q : ex_a_q;
        fwd_b    = ex_imm_q ? ex_b_q :
                   (mem_fwd && mem_rd_q == ex_rt_q) ? mem_data_q :
                   (wb_valid_q && wb_addr_q == ex_rt_q) ? wb_data_q : ex_b_q;
        alu_d    = (ex_q.op == OP_AND) ? fwd_a & fwd_b :
                   (ex_q.op == OP_OR)  ? fwd_a | fwd_b :
                   (ex_q.op == OP_ADD) ? fwd_a + fwd_b :
                   (ex_q.op == OP_SUB) ? fwd_a - fwd_b :
                   (ex_q.op == OP_SLT) ? XLEN'($signed(fwd_a) < $signed(fwd_b)) :
                   (ex_q.op == OP_MUL) ? fwd_a * fwd_b : '0;
        ex_stall = ex_q.valid && ex_q.op == OP_MUL && cnt_q != CW'(MUL_LAT - 1);
        cnt_d    = ex_stall ? cnt_q + 1'b1 : '0;
        ready    = bus.start_i && !ex_stall;
        fire     = bus.issue_valid_i && ready;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q        <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_imm_q    <= 1'b0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_rd_q    <= '0;
            mem_data_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (fire) begin
                ex_q     <= '{valid: 1'b1, op: bus.op_i, regwrite: bus.regwrite_i};
                ex_rs_q  <= bus.rs_i;
                ex_rt_q  <= bus.rt_i;
                ex_rd_q  <= bus.rd_i;
                ex_imm_q <= bus.use_imm_i;
                ex_a_q   <= rf_a;
                ex_b_q   <= bus.use_imm_i ? bus.imm_i : rf_b;
            end else if (ex_stall) begin
                // producers drain out of MEM/WB while MUL sits in EX, so freeze the forwarded operands
                ex_a_q <= fwd_a;
                ex_b_q <= fwd_b;
            end else begin
                ex_q.valid <= 1'b0;
            end
            mem_valid_q <= ex_q.valid && !ex_stall;
            mem_rw_q    <= ex_q.regwrite;
            mem_rd_q    <= ex_rd_q;
            mem_data_q  <= alu_d;
            wb_valid_q  <= mem_valid_q && mem_rw_q && mem_rd_q != '0;
            wb_addr_q   <= mem_rd_q;
            wb_data_q   <= mem_data_q;
        end
    end

    assign bus.issue_ready_o = ready;
    assign bus.wb_valid_o    = wb_valid_q;
    assign bus.wb_addr_o     = wb_addr_q;
    assign bus.wb_data_o     = wb_data_q;
endmodule

// File: tb/tb_alu_issue_pipe.sv
// tb_alu_issue_pipe: table-driven issue stream with a retire scoreboard, plus reset/back-pressure sequences
module tb_alu_issue_pipe;
    import pipe_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int NV      = 25;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic        use_imm, regwrite;
        logic [31:0] exp;
        int          waits;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          lat;
        int          cyc;
    } sb_t;

    logic clk, rst_n;
    int   cyc, n_chk, n_fail;
    vec_t tv [NV];
    sb_t  sbq [$];

    alu_issue_pipe_if #(.XLEN(32), .AW(5)) bus ();

    alu_issue_pipe #(.XLEN(32), .NREGS(32), .MUL_LAT(MUL_LAT)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dbg_chk(input int a, input logic [31:0] exp);
        bus.dbg_addr_i = 5'(a);
        #1;
        chk($sformatf("dbg_r%0d", a), bus.dbg_data_o, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input int rs, input int rt, input int rd,
                                input logic [31:0] imm, input logic ui, input logic rw,
                                input logic [31:0] exp, input int w);
        vec_t r;
        r.op = op; r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.imm = imm; r.use_imm = ui; r.regwrite = rw; r.exp = exp; r.waits = w;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        bus.op_i = v.op; bus.rs_i = v.rs; bus.rt_i = v.rt; bus.rd_i = v.rd;
        bus.imm_i = v.imm; bus.use_imm_i = v.use_imm; bus.regwrite_i = v.regwrite;
        bus.issue_valid_i = 1'b1;
    endtask

    // holds the op until the handshake completes; returns how many cycles ready was low
    task automatic send(input vec_t v, output int waits);
        bit done = 0;
        waits = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            drive(v);
            #4;
            if (bus.issue_ready_o) begin
                if (v.regwrite && v.rd != 0)
                    sbq.push_back('{v.rd, v.exp, (v.op == OP_MUL) ? MUL_LAT + 1 : 2, cyc + 1});
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: op rd=%0d never accepted", v.rd);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && bus.wb_valid_o) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_wb: addr %0d data %h with nothing pending", bus.wb_addr_o, bus.wb_data_o);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("wb_addr_r%0d", e.addr), 32'(bus.wb_addr_o), 32'(e.addr));
                chk($sformatf("wb_data_r%0d", e.addr), bus.wb_data_o, e.data);
                chk($sformatf("wb_latency_r%0d", e.addr), 32'(cyc - e.cyc), 32'(e.lat));
            end
        end
    end

    initial begin
        int w;
        n_chk = 0; n_fail = 0; cyc = 0;
        tv[0]  = mk(OP_ADD, 0, 0, 1, 5, 1, 1, 5, 0);
        tv[1]  = mk(OP_ADD, 1, 1, 2, 0, 0, 1, 10, 0);
        tv[2]  = mk(OP_SUB, 2, 1, 3, 0, 0, 1, 5, 0);
        tv[3]  = mk(OP_ADD, 0, 0, 4, 7, 1, 1, 7, 0);
        tv[4]  = mk(OP_AND, 1, 2, 13, 0, 0, 0, 0, 0);
        tv[5]  = mk(OP_OR,  1, 2, 14, 0, 0, 0, 0, 0);
        tv[6]  = mk(OP_ADD, 4, 4, 5, 0, 0, 1, 14, 0);
        tv[7]  = mk(OP_MUL, 1, 2, 6, 0, 0, 1, 50, 0);
        tv[8]  = mk(OP_ADD, 6, 1, 7, 0, 0, 1, 55, MUL_LAT - 1);
        tv[9]  = mk(OP_ADD, 0, 0, 0, 9, 1, 1, 0, 0);
        tv[10] = mk(OP_ADD, 0, 0, 8, 0, 0, 1, 0, 0);
        tv[11] = mk(OP_ADD, 0, 0, 9, 32'h7FFF_FFFF, 1, 1, 32'h7FFF_FFFF, 0);
        tv[12] = mk(OP_ADD, 9, 0, 10, 1, 1, 1, 32'h8000_0000, 0);
        tv[13] = mk(OP_SLT, 10, 9, 11, 0, 0, 1, 1, 0);
        tv[14] = mk(OP_AND, 9, 0, 12, 32'hF0, 1, 1, 32'hF0, 0);
        tv[15] = mk(OP_OR,  10, 1, 13, 0, 0, 1, 32'h8000_0005, 0);
        tv[16] = mk(OP_SUB, 0, 1, 14, 0, 0, 1, 32'hFFFF_FFFB, 0);
        tv[17] = mk(OP_MUL, 10, 2, 15, 0, 0, 1, 0, 0);
        tv[18] = mk(OP_MUL, 9, 9, 16, 0, 0, 1, 1, MUL_LAT - 1);
        tv[19] = mk(3'd4,   1, 2, 17, 0, 0, 1, 0, MUL_LAT - 1);
        tv[20] = mk(OP_SLT, 1, 14, 18, 0, 0, 1, 0, 0);
        tv[21] = mk(OP_MUL, 16, 1, 19, 0, 0, 1, 5, 0);
        tv[22] = mk(OP_ADD, 19, 0, 20, 3, 1, 1, 8, MUL_LAT - 1);
        tv[23] = mk(OP_MUL, 19, 20, 21, 0, 0, 1, 40, 0);
        tv[24] = mk(OP_ADD, 21, 21, 22, 0, 0, 1, 80, MUL_LAT - 1);

        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.issue_valid_i = 1'b0; bus.dbg_addr_i = '0;
        drive(tv[0]);
        bus.issue_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_wb_valid", 32'(bus.wb_valid_o), 0);
        chk("ready_start_low", 32'(bus.issue_ready_o), 0);
        for (int a = 0; a < 32; a++) dbg_chk(a, 0);
        bus.start_i = 1'b1;
        #1;
        chk("ready_start_high", 32'(bus.issue_ready_o), 1);

        // start low holds a valid op without transferring it
        @(negedge clk);
        bus.start_i = 1'b0;
        drive(tv[0]);
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("hold_ready_low", 32'(bus.issue_ready_o), 0);
            @(negedge clk);
        end
        bus.issue_valid_i = 1'b0;
        bus.start_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send(tv[i], w);
            chk($sformatf("ready_waits_%0d", i), 32'(w), 32'(tv[i].waits));
        end
        @(negedge clk);
        bus.issue_valid_i = 1'b0;
        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
        chk("drain_pending", 32'(sbq.size()), 0);
        for (int i = 0; i < NV; i++)
            if (tv[i].regwrite) dbg_chk(tv[i].rd, tv[i].exp);

        // reset while a MUL occupies EX: nothing may retire, every register clears
        send(mk(OP_MUL, 1, 2, 23, 0, 0, 1, 50, 0), w);
        @(negedge clk);
        bus.issue_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("mid_reset_wb_valid", 32'(bus.wb_valid_o), 0);
        chk("mid_reset_ready", 32'(bus.issue_ready_o), 1);
        for (int a = 0; a < 32; a++) dbg_chk(a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        dbg_chk(23, 0);
        dbg_chk(6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
